// File: rtl/jtkicker_romarb.sv
// Schedules cached ROM-slot misses (main CPU, scroll tiles, objects) onto the single
// SDRAM read port and keeps one cached entry per slot with a zero-latency hit path.
module jtkicker_romarb #(
    parameter logic [21:0] MAIN_OFFSET = 22'h0,
    parameter logic [21:0] SCR_OFFSET  = 22'h0,
    parameter logic [21:0] OBJ_OFFSET  = 22'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic        main_cs,
    input  logic [15:0] main_addr,
    output logic [7:0]  main_dout,
    output logic        main_ok,
    input  logic        scr_cs,
    input  logic [12:0] scr_addr,
    output logic [31:0] scr_dout,
    output logic        scr_ok,
    input  logic        obj_cs,
    input  logic [16:0] obj_addr,
    output logic [7:0]  obj_dout,
    output logic        obj_ok,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        data_dst,
    input  logic        data_rdy,
    input  logic [15:0] data_read,
    output logic [1:0]  dbg_state
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] SL_MAIN = 2'd0;
    localparam logic [1:0] SL_SCR  = 2'd1;
    localparam logic [1:0] SL_OBJ  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_slot;
    logic [21:0] r_sdram_addr;
    logic [16:0] r_pend_addr;
    logic [15:0] r_word0;

    logic [15:0] r_main_tag;
    logic [15:0] r_main_data;
    logic        r_main_valid;
    logic [12:0] r_scr_tag;
    logic [31:0] r_scr_data;
    logic        r_scr_valid;
    logic [16:0] r_obj_tag;
    logic [15:0] r_obj_data;
    logic        r_obj_valid;

    logic [21:0] w_main_wa;
    logic [21:0] w_scr_wa;
    logic [21:0] w_obj_wa;
    logic        w_main_ok;
    logic        w_scr_ok;
    logic        w_obj_ok;
    logic        w_main_miss;
    logic        w_scr_miss;
    logic        w_obj_miss;
    logic        w_any_miss;
    logic [1:0]  w_sel_slot;
    logic [21:0] w_sel_wa;
    logic [16:0] w_sel_pend;
    logic [15:0] w_first;

    assign w_main_wa = {7'd0, main_addr[15:1]} + MAIN_OFFSET;
    assign w_scr_wa  = {8'd0, scr_addr, 1'b0} + SCR_OFFSET;
    assign w_obj_wa  = {6'd0, obj_addr[16:1]} + OBJ_OFFSET;

    assign w_main_ok = main_cs & r_main_valid & (r_main_tag == main_addr);
    assign w_scr_ok  = scr_cs  & r_scr_valid  & (r_scr_tag  == scr_addr);
    assign w_obj_ok  = obj_cs  & r_obj_valid  & (r_obj_tag  == obj_addr);

    assign w_main_miss = main_cs & ~w_main_ok;
    assign w_scr_miss  = scr_cs  & ~w_scr_ok;
    assign w_obj_miss  = obj_cs  & ~w_obj_ok;
    assign w_any_miss  = w_main_miss | w_scr_miss | w_obj_miss;

    // Fixed priority: main > scroll > object.
    always_comb begin
        w_sel_slot = SL_OBJ;
        w_sel_wa   = w_obj_wa;
        w_sel_pend = obj_addr;
        if (w_main_miss) begin
            w_sel_slot = SL_MAIN;
            w_sel_wa   = w_main_wa;
            w_sel_pend = {1'b0, main_addr};
        end else if (w_scr_miss) begin
            w_sel_slot = SL_SCR;
            w_sel_wa   = w_scr_wa;
            w_sel_pend = {4'd0, scr_addr};
        end
    end

    // When both strobes coincide the bus word serves as word0 and word1.
    assign w_first = data_dst ? data_read : r_word0;

    // SDRAM handshake: sdram_req stays high with a stable sdram_addr until the cycle
    // sdram_ack is sampled; data_dst/data_rdy are only honoured after that, in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_slot       <= SL_MAIN;
            r_sdram_addr <= 22'd0;
            r_pend_addr  <= 17'd0;
            r_word0      <= 16'd0;
            r_main_tag   <= 16'd0;
            r_main_data  <= 16'd0;
            r_main_valid <= 1'b0;
            r_scr_tag    <= 13'd0;
            r_scr_data   <= 32'd0;
            r_scr_valid  <= 1'b0;
            r_obj_tag    <= 17'd0;
            r_obj_data   <= 16'd0;
            r_obj_valid  <= 1'b0;
        end else if (downloading) begin
            r_state      <= ST_IDLE;
            r_main_valid <= 1'b0;
            r_scr_valid  <= 1'b0;
            r_obj_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_miss) begin
                        r_state      <= ST_REQ;
                        r_slot       <= w_sel_slot;
                        r_sdram_addr <= w_sel_wa;
                        r_pend_addr  <= w_sel_pend;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (data_dst) r_word0 <= data_read;
                    if (data_rdy) begin
                        r_state <= ST_IDLE;
                        case (r_slot)
                            SL_MAIN: begin
                                r_main_tag   <= r_pend_addr[15:0];
                                r_main_data  <= w_first;
                                r_main_valid <= 1'b1;
                            end
                            SL_SCR: begin
                                r_scr_tag   <= r_pend_addr[12:0];
                                r_scr_data  <= {data_read, w_first};
                                r_scr_valid <= 1'b1;
                            end
                            default: begin
                                r_obj_tag   <= r_pend_addr;
                                r_obj_data  <= w_first;
                                r_obj_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign main_ok    = w_main_ok;
    assign scr_ok     = w_scr_ok;
    assign obj_ok     = w_obj_ok;
    assign main_dout  = r_main_tag[0] ? r_main_data[15:8] : r_main_data[7:0];
    assign scr_dout   = r_scr_data;
    assign obj_dout   = r_obj_tag[0] ? r_obj_data[15:8] : r_obj_data[7:0];
    assign sdram_req  = (r_state == ST_REQ);
    assign sdram_addr = r_sdram_addr;
    assign dbg_state  = r_state;
endmodule

// File: tb/tb_jtkicker_romarb.sv
// Bench for jtkicker_romarb: a small SDRAM responder plus queues of expected
// request addresses and expected slot data.
module tb_jtkicker_romarb;
    localparam logic [21:0] MAIN_OFF = 22'h0;
    localparam logic [21:0] SCR_OFF  = 22'h8000;
    localparam logic [21:0] OBJ_OFF  = 22'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic        main_cs;
    logic [15:0] main_addr;
    logic [7:0]  main_dout;
    logic        main_ok;
    logic        scr_cs;
    logic [12:0] scr_addr;
    logic [31:0] scr_dout;
    logic        scr_ok;
    logic        obj_cs;
    logic [16:0] obj_addr;
    logic [7:0]  obj_dout;
    logic        obj_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_dst;
    logic        data_rdy;
    logic [15:0] data_read;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_d_q[$];

    always #5 clk = ~clk;

    jtkicker_romarb #(
        .MAIN_OFFSET(MAIN_OFF),
        .SCR_OFFSET (SCR_OFF),
        .OBJ_OFFSET (OBJ_OFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .downloading(downloading),
        .main_cs    (main_cs),
        .main_addr  (main_addr),
        .main_dout  (main_dout),
        .main_ok    (main_ok),
        .scr_cs     (scr_cs),
        .scr_addr   (scr_addr),
        .scr_dout   (scr_dout),
        .scr_ok     (scr_ok),
        .obj_cs     (obj_cs),
        .obj_addr   (obj_addr),
        .obj_dout   (obj_dout),
        .obj_ok     (obj_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_dst   (data_dst),
        .data_rdy   (data_rdy),
        .data_read  (data_read),
        .dbg_state  (dbg_state)
    );

    function automatic logic slot_ok(input int s);
        case (s)
            0: return main_ok;
            1: return scr_ok;
            default: return obj_ok;
        endcase
    endfunction

    function automatic logic [31:0] slot_dout(input int s);
        case (s)
            0: return {24'd0, main_dout};
            1: return scr_dout;
            default: return {24'd0, obj_dout};
        endcase
    endfunction

    task automatic wait_req(input string name);
        int n = 0;
        logic [31:0] e;
        while (sdram_req !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL %s req_timeout sdram_req=%b required=1", name, sdram_req);
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_req sdram_addr=%h required=none", name, sdram_addr);
            return;
        end
        e = exp_q.pop_front();
        if (sdram_addr !== e[21:0]) begin
            errors++;
            $display("FAIL %s sdram_addr got=%h required=%h", name, sdram_addr, e[21:0]);
        end
    endtask

    task automatic ack_phase(input string name, input int dly);
        logic [21:0] hold;
        wait_req(name);
        hold = sdram_addr;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            checks++;
            if (sdram_req !== 1'b1 || sdram_addr !== hold) begin
                errors++;
                $display("FAIL %s req_hold req=%b addr=%h required req=1 addr=%h",
                         name, sdram_req, sdram_addr, hold);
            end
        end
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        checks++;
        if (sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL %s req_drop sdram_req=%b required=0", name, sdram_req);
        end
    endtask

    task automatic data_phase(input string name, input int slot, input logic [15:0] w0,
                              input logic [15:0] w1, input bit same);
        checks++;
        if (slot_ok(slot) !== 1'b0) begin
            errors++;
            $display("FAIL %s early_ok ok=%b required=0", name, slot_ok(slot));
        end
        data_read = w0;
        data_dst  = 1'b1;
        data_rdy  = same;
        @(negedge clk);
        if (!same) begin
            checks++;
            if (slot_ok(slot) !== 1'b0) begin
                errors++;
                $display("FAIL %s ok_before_rdy ok=%b required=0", name, slot_ok(slot));
            end
            data_dst  = 1'b0;
            data_rdy  = 1'b1;
            data_read = w1;
            @(negedge clk);
        end
        data_dst  = 1'b0;
        data_rdy  = 1'b0;
        data_read = 16'h0;
    endtask

    task automatic check_result(input string name, input int slot);
        logic [31:0] e;
        checks++;
        if (exp_d_q.size() == 0) begin
            errors++;
            $display("FAIL %s no_expected_data", name);
            return;
        end
        e = exp_d_q.pop_front();
        if (slot_ok(slot) !== 1'b1 || slot_dout(slot) !== e) begin
            errors++;
            $display("FAIL %s result ok=%b dout=%h required ok=1 dout=%h",
                     name, slot_ok(slot), slot_dout(slot), e);
        end
    endtask

    task automatic serve(input string name, input int slot, input int dly,
                         input logic [15:0] w0, input logic [15:0] w1, input bit same);
        ack_phase(name, dly);
        data_phase(name, slot, w0, w1, same);
        check_result(name, slot);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        main_cs = 1'b1; scr_cs = 1'b1; obj_cs = 1'b1;
        main_addr = 16'h0100; scr_addr = 13'h0001; obj_addr = 17'h00003;
        repeat (3) @(negedge clk);
        checks++;
        if ({main_ok, scr_ok, obj_ok} !== 3'b000 || sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ok ok=%b req=%b required ok=000 req=0",
                     {main_ok, scr_ok, obj_ok}, sdram_req);
        end
        checks++;
        if (main_dout !== 8'h0 || scr_dout !== 32'h0 || obj_dout !== 8'h0 || sdram_addr !== 22'h0) begin
            errors++;
            $display("FAIL reset_data main=%h scr=%h obj=%h addr=%h required all 0",
                     main_dout, scr_dout, obj_dout, sdram_addr);
        end
        rst = 1'b0;
        exp_q.push_back(32'h80);
        exp_d_q.push_back(32'h66);
        @(negedge clk);
        scr_cs = 1'b0; obj_cs = 1'b0;
        serve("reset_first_main", 0, 1, 16'h5566, 16'h0000, 1'b0);
        main_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_main_miss();
        main_addr = 16'h1235; main_cs = 1'b1;
        exp_q.push_back(32'h091A);
        exp_d_q.push_back(32'hAB);
        serve("main_miss", 0, 3, 16'hAB12, 16'h0000, 1'b0);
        main_cs = 1'b0;
        @(negedge clk);
        main_cs = 1'b1;
        #1;
        checks++;
        if (main_ok !== 1'b1 || main_dout !== 8'hAB) begin
            errors++;
            $display("FAIL main_hit ok=%b dout=%h required ok=1 dout=ab", main_ok, main_dout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (sdram_req !== 1'b0) begin
                errors++;
                $display("FAIL main_hit_noreq sdram_req=%b required=0", sdram_req);
            end
        end
        main_addr = 16'h1234;
        exp_q.push_back(32'h091A);
        exp_d_q.push_back(32'h12);
        serve("main_low_byte", 0, 1, 16'hAB12, 16'h0000, 1'b1);
        main_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        main_addr = 16'h2000; scr_addr = 13'h0010; obj_addr = 17'h00401;
        main_cs = 1'b1; scr_cs = 1'b1; obj_cs = 1'b1;
        exp_q.push_back(32'h1000);
        exp_q.push_back(32'h8020);
        exp_q.push_back(32'h300);
        exp_d_q.push_back(32'h57);
        exp_d_q.push_back(32'h5555_AAAA);
        exp_d_q.push_back(32'hC3);
        serve("prio_main", 0, 1, 16'h1357, 16'h0000, 1'b0);
        checks++;
        if (scr_ok !== 1'b0 || obj_ok !== 1'b0) begin
            errors++;
            $display("FAIL prio_others_pending scr_ok=%b obj_ok=%b required 0 0", scr_ok, obj_ok);
        end
        serve("prio_scr", 1, 0, 16'hAAAA, 16'h5555, 1'b0);
        serve("prio_obj", 2, 2, 16'hC3D4, 16'h0000, 1'b1);
        checks++;
        if (main_ok !== 1'b1 || scr_ok !== 1'b1) begin
            errors++;
            $display("FAIL prio_all_hit main_ok=%b scr_ok=%b required 1 1", main_ok, scr_ok);
        end
        main_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_scroll();
        scr_addr = 13'h0004; scr_cs = 1'b1;
        exp_q.push_back(32'h8008);
        exp_d_q.push_back(32'h2222_1111);
        serve("scroll_32", 1, 0, 16'h1111, 16'h2222, 1'b0);
        scr_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_change();
        obj_addr = 17'h00010; obj_cs = 1'b1;
        exp_q.push_back(32'h108);
        exp_q.push_back(32'h110);
        exp_d_q.push_back(32'h88);
        ack_phase("addr_chg_first", 1);
        obj_addr = 17'h00020;
        data_phase("addr_chg_first", 2, 16'h3344, 16'h0000, 1'b1);
        checks++;
        if (obj_ok !== 1'b0) begin
            errors++;
            $display("FAIL addr_chg_stale_ok obj_ok=%b required=0", obj_ok);
        end
        serve("addr_chg_second", 2, 0, 16'h7788, 16'h0000, 1'b1);
        obj_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_download();
        scr_addr = 13'h0004; scr_cs = 1'b1;
        #1;
        checks++;
        if (scr_ok !== 1'b1) begin
            errors++;
            $display("FAIL dl_scr_hit scr_ok=%b required=1", scr_ok);
        end
        main_addr = 16'h4000; main_cs = 1'b1;
        exp_q.push_back(32'h2000);
        wait_req("dl_pre");
        downloading = 1'b1;
        @(negedge clk);
        checks++;
        if (sdram_req !== 1'b0 || {main_ok, scr_ok, obj_ok} !== 3'b000) begin
            errors++;
            $display("FAIL dl_abort req=%b ok=%b required req=0 ok=000",
                     sdram_req, {main_ok, scr_ok, obj_ok});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (sdram_req !== 1'b0 || scr_ok !== 1'b0) begin
                errors++;
                $display("FAIL dl_hold req=%b scr_ok=%b required 0 0", sdram_req, scr_ok);
            end
        end
        downloading = 1'b0;
        exp_q.push_back(32'h2000);
        exp_q.push_back(32'h8008);
        exp_d_q.push_back(32'h0E);
        exp_d_q.push_back(32'hCAFE_BEEF);
        serve("dl_main_retry", 0, 1, 16'h0F0E, 16'h0000, 1'b0);
        serve("dl_scr_refill", 1, 1, 16'hBEEF, 16'hCAFE, 1'b0);
        main_cs = 1'b0; scr_cs = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; downloading = 1'b0;
        main_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
        main_addr = 16'h0; scr_addr = 13'h0; obj_addr = 17'h0;
        sdram_ack = 1'b0; data_dst = 1'b0; data_rdy = 1'b0; data_read = 16'h0;
        test_reset();
        test_main_miss();
        test_priority();
        test_scroll();
        test_addr_change();
        test_download();
        checks++;
        if (exp_q.size() != 0 || exp_d_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations addr=%0d data=%0d required 0 0",
                     exp_q.size(), exp_d_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
